net_gen: RTL and testbench

Parametrised centre-net generator for the pong playfield, driven from the shared `hpos`/`vpos` video counters. It produces a registered one-bit net pixel stream with a configurable column position and width, vertical extent, and dash geometry. Four runtime modes are available: off, solid, dashed, and dashed with a one-line-per-frame scroll. Mode writes are double-buffered and take effect only at frame start, so a frame is never torn. Output feeds the playfield graphics OR-tree alongside ball and paddles.

---
 rtl/net_gen.sv | 103 ++++++++++
 tb/tb_net_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/net_gen.sv
// Centre-net pixel generator for the pong playfield: off / solid / dashed / scrolling dashed.
// One-clock registered output; mode writes are staged and committed only at frame start.
module net_gen #(
  parameter int H_BITS      = 9,
  parameter int V_BITS      = 9,
  parameter int NET_X       = 128,
  parameter int NET_W       = 2,
  parameter int V_TOP       = 0,
  parameter int V_BOTTOM    = 239,
  parameter int DASH_PERIOD = 8,
  parameter int DASH_ON     = 4,
  parameter int RESET_MODE  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [H_BITS-1:0] hpos,
  input  logic [V_BITS-1:0] vpos,
  input  logic              display_on,
  input  logic [1:0]        mode,
  input  logic              mode_wr,
  output logic              net_gfx,
  output logic [1:0]        mode_active
);

  localparam int CW = (DASH_PERIOD > 1) ? $clog2(DASH_PERIOD) : 1;
  localparam logic [CW-1:0]     LAST   = CW'(DASH_PERIOD - 1);
  localparam logic [CW:0]       ON_LIM = (CW + 1)'(DASH_ON);
  localparam logic [H_BITS-1:0] X_LO   = H_BITS'(NET_X);
  localparam logic [H_BITS-1:0] X_SPAN = H_BITS'(NET_W - 1);
  localparam logic [V_BITS-1:0] Y_LO   = V_BITS'(V_TOP);
  localparam logic [V_BITS-1:0] Y_SPAN = V_BITS'(V_BOTTOM - V_TOP);

  logic [1:0]        pending_mode;
  logic [1:0]        active_mode;
  logic [CW-1:0]     scroll_ofs;
  logic [CW-1:0]     dash_cnt;

  logic              frame_start;
  logic [CW-1:0]     scroll_nxt;
  logic [CW-1:0]     dash_nxt;
  logic [H_BITS-1:0] dx;
  logic [V_BITS-1:0] dy;
  logic              in_x;
  logic              in_v;
  logic              dash_lit;
  logic              mode_lit;

  always_comb begin
    frame_start = (hpos == '0) && (vpos == '0);

    scroll_nxt = scroll_ofs;
    if (frame_start) begin
      if (pending_mode == 2'd3)
        scroll_nxt = (scroll_ofs == LAST) ? '0 : scroll_ofs + CW'(1);
      else
        scroll_nxt = '0;
    end

    // Dash counter counts every line regardless of mode; the frame's first line loads the scroll phase.
    dash_nxt = dash_cnt;
    if (hpos == '0) begin
      if (vpos == '0)
        dash_nxt = scroll_nxt;
      else
        dash_nxt = (dash_cnt == LAST) ? '0 : dash_cnt + CW'(1);
    end

    // Offset-and-span window tests stay exact at full width and avoid compares against zero.
    dx   = hpos - X_LO;
    dy   = vpos - Y_LO;
    in_x = (dx <= X_SPAN);
    in_v = (dy <= Y_SPAN);

    dash_lit = ({1'b0, dash_cnt} < ON_LIM);
    mode_lit = 1'b0;
    case (active_mode)
      2'd0:    mode_lit = 1'b0;
      2'd1:    mode_lit = 1'b1;
      default: mode_lit = dash_lit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_mode <= 2'(RESET_MODE);
      active_mode  <= 2'(RESET_MODE);
      scroll_ofs   <= '0;
      dash_cnt     <= '0;
      net_gfx      <= 1'b0;
    end else begin
      if (mode_wr)
        pending_mode <= mode;
      if (frame_start)
        active_mode <= pending_mode;
      scroll_ofs <= scroll_nxt;
      dash_cnt   <= dash_nxt;
      net_gfx    <= display_on & in_x & in_v & mode_lit;
    end
  end

  assign mode_active = active_mode;

endmodule

// File: tb/tb_net_gen.sv
// Directed bench for net_gen: default, solid/off, scroll, boundary write, window edges, mid-frame reset.
module tb_net_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       display_on;
  logic [1:0] mode;
  logic       mode_wr;
  logic       net_gfx;
  logic [1:0] mode_active;

  logic       reset2 = 1'b1;
  logic [8:0] hpos2 = '0;
  logic [8:0] vpos2 = '0;
  logic       display_on2 = 1'b0;
  logic [1:0] mode2 = 2'd1;
  logic       mode_wr2 = 1'b0;
  logic       net_gfx2;
  logic [1:0] mode_active2;

  int checks = 0;
  int errors = 0;

  net_gen dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .mode(mode), .mode_wr(mode_wr), .net_gfx(net_gfx), .mode_active(mode_active)
  );

  net_gen #(
    .NET_X(1), .NET_W(1), .V_TOP(10), .V_BOTTOM(10), .RESET_MODE(1)
  ) dut_win (
    .clk(clk), .reset(reset2), .hpos(hpos2), .vpos(vpos2), .display_on(display_on2),
    .mode(mode2), .mode_wr(mode_wr2), .net_gfx(net_gfx2), .mode_active(mode_active2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int h, input int v, input logic d);
    hpos = 9'(h);
    vpos = 9'(v);
    display_on = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input int h, input int v, input logic d);
    hpos2 = 9'(h);
    vpos2 = 9'(v);
    display_on2 = d;
    @(posedge clk);
    #1;
  endtask

  // One frame over lines 0..stop_line-1, sampling columns around the net.
  // em/es: hand-computed active mode and scroll phase for this frame.
  task automatic run_frame(input int em, input int es, input int wr_line,
                           input logic [1:0] wm, input int stop_line);
    int  hs[5] = '{0, 127, 128, 129, 130};
    bit  lit;
    bit  exp;
    for (int v = 0; v < stop_line; v++) begin
      for (int i = 0; i < 5; i++) begin
        mode    = wm;
        mode_wr = (v == wr_line) && (i == 0);
        step(hs[i], v, 1'b1);
        mode_wr = 1'b0;
        if (v == 0 && i == 0)
          chk("mode_active at frame start", {6'b0, mode_active}, 8'(em));
        case (em)
          0:       lit = 1'b0;
          1:       lit = 1'b1;
          default: lit = ((es + v) % 8) < 4;
        endcase
        exp = (hs[i] == 128 || hs[i] == 129) && (v <= 239) && lit;
        chk($sformatf("net_gfx m%0d s%0d v%0d h%0d", em, es, v, hs[i]),
            {7'b0, net_gfx}, {7'b0, exp});
      end
    end
  endtask

  initial begin
    int cnt;
    bit exp;
    reset = 1'b1; mode = 2'd0; mode_wr = 1'b0;
    // Inputs that would light the net if reset did not hold the output low.
    for (int i = 0; i < 3; i++) begin
      step(128, 4, 1'b1);
      chk("net_gfx in reset", {7'b0, net_gfx}, 8'd0);
      chk("mode_active in reset", {6'b0, mode_active}, 8'd2);
    end
    reset = 1'b0;

    run_frame(2, 0, -1, 2'd0, 250);   // defaults: dashed, phase 0
    run_frame(2, 0, 120, 2'd1, 250);  // solid written mid-frame, still dashed
    run_frame(1, 0, 60, 2'd0, 250);   // solid; off written
    run_frame(0, 0, 60, 2'd3, 250);   // off; scroll written
    for (int k = 1; k <= 9; k++)
      run_frame(3, k % 8, (k == 9) ? 50 : -1, 2'd1, 250);
    run_frame(1, 0, -1, 2'd0, 250);   // solid
    run_frame(1, 0, 0, 2'd0, 250);    // off written on the boundary edge: still solid
    run_frame(0, 0, 30, 2'd3, 250);   // off; scroll written
    for (int k = 1; k <= 5; k++)
      run_frame(3, k, -1, 2'd0, 250);
    run_frame(3, 6, -1, 2'd0, 100);

    // Reset at line 100 together with a competing write; reset must win.
    reset = 1'b1; mode = 2'd3; mode_wr = 1'b1;
    step(128, 100, 1'b1);
    reset = 1'b0; mode_wr = 1'b0;
    chk("net_gfx after mid reset", {7'b0, net_gfx}, 8'd0);
    chk("mode_active after mid reset", {6'b0, mode_active}, 8'd2);
    run_frame(2, 0, -1, 2'd0, 250);   // phase realigned: line 0 lit

    // Window-edge instance: single lit pixel at (1,10).
    for (int i = 0; i < 2; i++) begin
      step2(1, 10, 1'b1);
      chk("win net_gfx in reset", {7'b0, net_gfx2}, 8'd0);
    end
    reset2 = 1'b0;
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      for (int v = 0; v < 13; v++) begin
        for (int h = 0; h < 4; h++) begin
          step2(h, v, !(f == 1 && h == 1 && v == 10));
          exp = (f == 0) && (h == 1) && (v == 10);
          chk($sformatf("win net_gfx f%0d v%0d h%0d", f, v, h), {7'b0, net_gfx2}, {7'b0, exp});
          cnt += int'(net_gfx2 === 1'b1);
        end
      end
      chk($sformatf("win lit count f%0d", f), 8'(cnt), (f == 0) ? 8'd1 : 8'd0);
      chk("win mode_active", {6'b0, mode_active2}, 8'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
